fetch_pc_ctrl: RTL and testbench

FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

---
 rtl/fetch_pc_ctrl_pkg.sv | 22 ++
 rtl/fetch_pc_ctrl_npc_target.sv | 32 +++
 rtl/fetch_pc_ctrl.sv | 97 +++++++++
 tb/tb_fetch_pc_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared definitions for the fetch-stage PC controller: D-stage control
// transfer op encodings, the reset fetch address and a small op classifier.
package fetch_pc_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_BEQ    = 3'd1,
        OP_BLEZAL = 3'd2,
        OP_J      = 3'd3,
        OP_JAL    = 3'd4,
        OP_JR     = 3'd5
    } d_op_e;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    // True for every op that is a control transfer (taken or not).
    // Codes 6 and 7 are reserved and behave as no-ops.
    function automatic logic is_ctl_op(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd5);
    endfunction

endpackage

// File: rtl/fetch_pc_ctrl_npc_target.sv
// Combinational next-PC target for the control transfer currently in D.
// Branches are relative to the delay slot (d_pc+4); jumps keep the delay
// slot's top nibble; jr uses the forwarded rs value as-is.
module npc_target
    import fetch_pc_ctrl_pkg::*;
(
    input  logic [2:0]  d_op,
    input  logic [31:0] d_pc,
    input  logic [15:0] d_imm16,
    input  logic [25:0] d_index,
    input  logic [31:0] d_rs_val,
    output logic [31:0] target
);

    logic [31:0] seq_pc_s;
    logic [31:0] br_off_s;

    assign seq_pc_s = d_pc + 32'd4;
    assign br_off_s = {{14{d_imm16[15]}}, d_imm16, 2'b00};

    // Select the transfer target by op; non-transfer ops fall back to the slot PC.
    always_comb begin
        target = seq_pc_s;
        case (d_op)
            OP_BEQ, OP_BLEZAL: target = seq_pc_s + br_off_s;
            OP_J, OP_JAL:      target = {seq_pc_s[31:28], d_index, 2'b00};
            OP_JR:             target = d_rs_val;
            default:           target = seq_pc_s;
        endcase
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC register with delay-slot redirect, link write request,
// control-transfer statistics and a sticky misaligned-target flag.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  d_op,
    input  logic [31:0] d_pc,
    input  logic [15:0] d_imm16,
    input  logic [25:0] d_index,
    input  logic [31:0] d_rs_val,
    input  logic        beq_zero,
    input  logic        blezal,
    output logic [31:0] pc_f,
    output logic        redirect,
    output logic        link_we,
    output logic [31:0] link_addr,
    output logic [31:0] br_cnt,
    output logic [31:0] taken_cnt,
    output logic        align_err
);

    logic [31:0] target_s;
    logic        taken_s;
    logic        link_we_s;
    logic [31:0] pc_f_r;
    logic        redirect_r;
    logic [31:0] br_cnt_r;
    logic [31:0] taken_cnt_r;
    logic        align_err_r;

    npc_target u_npc_target (
        .d_op     (d_op),
        .d_pc     (d_pc),
        .d_imm16  (d_imm16),
        .d_index  (d_index),
        .d_rs_val (d_rs_val),
        .target   (target_s)
    );

    // Decide whether the instruction in D transfers control this cycle.
    always_comb begin
        taken_s = 1'b0;
        case (d_op)
            OP_BEQ:              taken_s = beq_zero;
            OP_BLEZAL:           taken_s = blezal;
            OP_J, OP_JAL, OP_JR: taken_s = 1'b1;
            default:             taken_s = 1'b0;
        endcase
    end

    // Link write only for an unstalled jal or a taken blezal.
    always_comb begin
        link_we_s = 1'b0;
        if (!stall) begin
            link_we_s = (d_op == OP_JAL) || ((d_op == OP_BLEZAL) && blezal);
        end else begin
            link_we_s = 1'b0;
        end
    end

    // PC, redirect pulse, statistics and sticky alignment flag; a stall freezes all but redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_r      <= RESET_PC;
            redirect_r  <= 1'b0;
            br_cnt_r    <= 32'd0;
            taken_cnt_r <= 32'd0;
            align_err_r <= 1'b0;
        end else if (stall) begin
            redirect_r  <= 1'b0;
        end else begin
            pc_f_r     <= taken_s ? target_s : (pc_f_r + 32'd4);
            redirect_r <= taken_s;
            if (is_ctl_op(d_op)) begin
                br_cnt_r <= br_cnt_r + 32'd1;
            end
            if (taken_s) begin
                taken_cnt_r <= taken_cnt_r + 32'd1;
                if (target_s[1:0] != 2'b00) begin
                    align_err_r <= 1'b1;
                end
            end
        end
    end

    assign pc_f      = pc_f_r;
    assign redirect  = redirect_r;
    assign br_cnt    = br_cnt_r;
    assign taken_cnt = taken_cnt_r;
    assign align_err = align_err_r;
    assign link_we   = link_we_s;
    assign link_addr = d_pc + 32'd8;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: a cycle-level reference model plus
// hand-computed literal checks of the directed scenarios.
module tb_fetch_pc_ctrl;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  d_op;
    logic [31:0] d_pc;
    logic [15:0] d_imm16;
    logic [25:0] d_index;
    logic [31:0] d_rs_val;
    logic        beq_zero;
    logic        blezal;
    logic [31:0] pc_f;
    logic        redirect;
    logic        link_we;
    logic [31:0] link_addr;
    logic [31:0] br_cnt;
    logic [31:0] taken_cnt;
    logic        align_err;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;
    int preload_seq = 0;
    int preload_seen = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_redirect;
    logic [31:0] m_br;
    logic [31:0] m_taken;
    logic        m_align;

    fetch_pc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .d_op      (d_op),
        .d_pc      (d_pc),
        .d_imm16   (d_imm16),
        .d_index   (d_index),
        .d_rs_val  (d_rs_val),
        .beq_zero  (beq_zero),
        .blezal    (blezal),
        .pc_f      (pc_f),
        .redirect  (redirect),
        .link_we   (link_we),
        .link_addr (link_addr),
        .br_cnt    (br_cnt),
        .taken_cnt (taken_cnt),
        .align_err (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic mdl_is_taken(input logic [2:0] op, input logic bz, input logic bl);
        if (op == 3'd1) return bz;
        if (op == 3'd2) return bl;
        return (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    endfunction

    function automatic logic [31:0] mdl_target(input logic [2:0] op, input logic [31:0] pc,
                                               input logic [15:0] imm, input logic [25:0] idx,
                                               input logic [31:0] rs);
        int off;
        off = $signed(imm);
        if (op == 3'd1 || op == 3'd2) return pc + 32'd4 + 32'(off * 4);
        if (op == 3'd3 || op == 3'd4) return ((pc + 32'd4) & 32'hF000_0000) | ({6'd0, idx} << 2);
        return rs;
    endfunction

    logic        mdl_tk;
    logic [31:0] mdl_tg;
    logic [31:0] mdl_base;
    logic        mdl_ctl;
    assign mdl_tk   = mdl_is_taken(d_op, beq_zero, blezal);
    assign mdl_tg   = mdl_target(d_op, d_pc, d_imm16, d_index, d_rs_val);
    assign mdl_base = (preload_seq != preload_seen) ? 32'hFFFF_FFFF : m_taken;
    assign mdl_ctl  = (d_op >= 3'd1) && (d_op <= 3'd5);

    // Reference model: advance architectural state on each rising edge.
    always @(posedge clk) begin
        preload_seen <= preload_seq;
        if (reset) begin
            m_pc       <= 32'h0000_3000;
            m_redirect <= 1'b0;
            m_br       <= 32'd0;
            m_taken    <= 32'd0;
            m_align    <= 1'b0;
        end else if (stall) begin
            m_redirect <= 1'b0;
            m_taken    <= mdl_base;
        end else begin
            m_pc       <= mdl_tk ? mdl_tg : m_pc + 32'd4;
            m_redirect <= mdl_tk;
            m_br       <= m_br + (mdl_ctl ? 32'd1 : 32'd0);
            m_taken    <= mdl_base + (mdl_tk ? 32'd1 : 32'd0);
            if (mdl_tk && (mdl_tg[1:0] != 2'b00)) m_align <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc_f", pc_f, m_pc);
            chk("redirect", {31'd0, redirect}, {31'd0, m_redirect});
            chk("br_cnt", br_cnt, m_br);
            chk("taken_cnt", taken_cnt, m_taken);
            chk("align_err", {31'd0, align_err}, {31'd0, m_align});
            chk("link_we", {31'd0, link_we},
                {31'd0, !stall && ((d_op == 3'd4) || ((d_op == 3'd2) && blezal))});
            chk("link_addr", link_addr, d_pc + 32'd8);
        end
    end

    // Apply one cycle of D-stage inputs just after a rising edge, return at the falling edge.
    task automatic drive(input logic st, input logic [2:0] op, input logic [31:0] pc,
                         input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] rs,
                         input logic bz, input logic bl);
        @(posedge clk);
        #2;
        stall    = st;
        d_op     = op;
        d_pc     = pc;
        d_imm16  = imm;
        d_index  = idx;
        d_rs_val = rs;
        beq_zero = bz;
        blezal   = bl;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; d_op = 3'd0; d_pc = 32'h0; d_imm16 = 16'h0;
        d_index = 26'h0; d_rs_val = 32'h0; beq_zero = 1'b0; blezal = 1'b0;

        // Reset and sequential fetch
        idle();
        chk("lit_reset_pc", pc_f, 32'h0000_3000);
        chk("lit_reset_redirect", {31'd0, redirect}, 32'd0);
        chk("lit_reset_br", br_cnt, 32'd0);
        chk_en = 1'b1;
        reset = 1'b0;
        idle();
        chk("lit_seq_3004", pc_f, 32'h0000_3004);
        idle();
        chk("lit_seq_3008", pc_f, 32'h0000_3008);

        // beq taken then not taken
        drive(1'b0, 3'd1, 32'h0000_3000, 16'h0003, 26'h0, 32'h0, 1'b1, 1'b0);
        idle();
        chk("lit_beq_pc", pc_f, 32'h0000_3010);
        chk("lit_beq_redirect", {31'd0, redirect}, 32'd1);
        chk("lit_beq_taken", taken_cnt, 32'd1);
        drive(1'b0, 3'd1, 32'h0000_3014, 16'h0003, 26'h0, 32'h0, 1'b0, 1'b0);
        chk("lit_redirect_drop", {31'd0, redirect}, 32'd0);
        idle();
        chk("lit_beq_nt_pc", pc_f, 32'h0000_3018);
        chk("lit_beq_nt_taken", taken_cnt, 32'd1);
        chk("lit_beq_nt_br", br_cnt, 32'd2);

        // blezal taken (links) then not taken (no link)
        drive(1'b0, 3'd2, 32'h0000_3008, 16'hFFFE, 26'h0, 32'h0, 1'b0, 1'b1);
        chk("lit_blezal_we", {31'd0, link_we}, 32'd1);
        chk("lit_blezal_addr", link_addr, 32'h0000_3010);
        drive(1'b0, 3'd2, 32'h0000_3010, 16'hFFFE, 26'h0, 32'h0, 1'b0, 1'b0);
        chk("lit_blezal_pc", pc_f, 32'h0000_3004);
        chk("lit_blezal_nt_we", {31'd0, link_we}, 32'd0);
        idle();
        chk("lit_blezal_nt_pc", pc_f, 32'h0000_3008);

        // Stalled jal must not link; stalled taken beq held two cycles
        drive(1'b1, 3'd4, 32'h0000_3100, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        chk("lit_stall_jal_we", {31'd0, link_we}, 32'd0);
        drive(1'b1, 3'd1, 32'h0000_3100, 16'h0003, 26'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 3'd1, 32'h0000_3100, 16'h0003, 26'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 3'd1, 32'h0000_3100, 16'h0003, 26'h0, 32'h0, 1'b1, 1'b0);
        chk("lit_stall_pc_hold", pc_f, 32'h0000_300C);
        chk("lit_stall_br_hold", br_cnt, 32'd4);
        chk("lit_stall_taken_hold", taken_cnt, 32'd2);
        idle();
        chk("lit_unstall_pc", pc_f, 32'h0000_3110);
        chk("lit_unstall_br", br_cnt, 32'd5);
        chk("lit_unstall_taken", taken_cnt, 32'd3);

        // jr to misaligned target: sticky align_err
        drive(1'b0, 3'd5, 32'h0000_3110, 16'h0, 26'h0, 32'h0000_3002, 1'b0, 1'b0);
        idle();
        chk("lit_jr_pc", pc_f, 32'h0000_3002);
        chk("lit_jr_align", {31'd0, align_err}, 32'd1);
        drive(1'b0, 3'd1, 32'h0000_3000, 16'h0003, 26'h0, 32'h0, 1'b1, 1'b0);
        idle();
        chk("lit_align_sticky", {31'd0, align_err}, 32'd1);

        // PC wrap on sequential increment
        drive(1'b0, 3'd5, 32'h0000_3010, 16'h0, 26'h0, 32'hFFFF_FFFC, 1'b0, 1'b0);
        idle();
        chk("lit_wrap_top", pc_f, 32'hFFFF_FFFC);
        idle();
        chk("lit_wrap_zero", pc_f, 32'h0000_0000);

        // Reset in the middle of a stalled taken branch
        reset = 1'b1;
        drive(1'b1, 3'd1, 32'h0000_3000, 16'h0003, 26'h0, 32'h0, 1'b1, 1'b0);
        chk("lit_rst_pc", pc_f, 32'h0000_3000);
        chk("lit_rst_align", {31'd0, align_err}, 32'd0);
        chk("lit_rst_taken", taken_cnt, 32'd0);
        reset = 1'b0;
        idle();
        idle();
        chk("lit_post_rst_pc", pc_f, 32'h0000_3004);

        // Preload taken counter to all-ones, then a taken j wraps it
        #1;
        force dut.taken_cnt_r = 32'hFFFF_FFFF;
        #1;
        release dut.taken_cnt_r;
        preload_seq = preload_seq + 1;
        drive(1'b0, 3'd3, 32'h4000_0000, 16'h0, 26'h000_0100, 32'h0, 1'b0, 1'b0);
        chk("lit_preload", taken_cnt, 32'hFFFF_FFFF);
        idle();
        chk("lit_j_pc", pc_f, 32'h4000_0400);
        chk("lit_taken_wrap", taken_cnt, 32'd0);
        chk("lit_j_br", br_cnt, 32'd1);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
